// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared encodings and constants for the sequential BCD converter
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int         BCD_DIGIT_W = 4;
  localparam logic [3:0] ADD3_THRESH = 4'd5;

endpackage

// File: rtl/madd3.sv
// rtl/madd3.sv - double-dabble digit adjust: add 3 when the digit is 5 or more
import bcd_pkg::*;

module madd3 (
  input  logic [3:0] x,
  output logic [3:0] y
);

  // Inputs never exceed 9, so the sum stays within 4 bits.
  assign y = (x >= ADD3_THRESH) ? x + 4'd3 : x;

endmodule

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - one-bit-per-clock binary to packed BCD converter
import bcd_pkg::*;

module bin2bcd_seq #(
  parameter int N_BITS   = 8,
  parameter int N_DIGITS = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [N_BITS-1:0]               bin,
  output logic                            busy,
  output logic                            done,
  output logic [BCD_DIGIT_W*N_DIGITS-1:0] bcd
);

  localparam int DW = BCD_DIGIT_W * N_DIGITS;
  localparam int CW = $clog2(N_BITS + 1);
  localparam int WW = DW + N_BITS;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [WW-1:0]   w;
  logic [DW-1:0]   adj;
  logic [WW-1:0]   shifted;

  genvar gi;
  generate
    for (gi = 0; gi < N_DIGITS; gi++) begin : g_digit
      madd3 u_madd3 (
        .x(w[N_BITS + BCD_DIGIT_W*gi +: BCD_DIGIT_W]),
        .y(adj[BCD_DIGIT_W*gi +: BCD_DIGIT_W])
      );
    end
  endgenerate

  // Adjust precedes the shift, so the final digits are never adjusted again.
  assign shifted = {adj, w[N_BITS-1:0]} << 1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      bcd   <= '0;
      cnt   <= '0;
      w     <= '0;
    end else begin
      case (state)
        ST_SHIFT: begin
          w   <= shifted;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(N_BITS - 1)) begin
            bcd   <= shifted[WW-1 -: DW];
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          // IDLE and DONE both accept a new request, allowing back-to-back conversions.
          done <= 1'b0;
          if (start) begin
            w     <= {{DW{1'b0}}, bin};
            cnt   <= '0;
            state <= ST_SHIFT;
            busy  <= 1'b1;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - directed self-checking bench for bin2bcd_seq
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  bin;
  logic        busy;
  logic        done;
  logic [11:0] bcd;

  int n_cmp = 0;
  int n_err = 0;

  bin2bcd_seq #(.N_BITS(8), .N_DIGITS(3)) dut (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  function automatic logic [11:0] bcd_ref(input int x);
    logic [3:0] h, t, o;
    h = 4'(x / 100);
    t = 4'((x / 10) % 10);
    o = 4'(x % 10);
    return {h, t, o};
  endfunction

  task automatic convert(input logic [7:0] b, input logic [11:0] exp, input string tag);
    int cyc;
    start = 1'b1;
    bin   = b;
    tick();
    start = 1'b0;
    check({tag, "_busy"}, busy, 1);
    wait_done(cyc);
    check({tag, "_lat"}, cyc, 8);
    check({tag, "_bcd"}, bcd, exp);
    tick();
    check({tag, "_pulse"}, done, 0);
    check({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int cyc;
    int pulses;
    rst = 1'b1; start = 1'b0; bin = 8'd0;
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_bcd", bcd, 12'h000);
    rst = 1'b0;
    tick();

    convert(8'd0,   12'h000, "b0");
    convert(8'd255, 12'h255, "b255");
    convert(8'd128, 12'h128, "b128");
    convert(8'd99,  12'h099, "b99");

    // start during SHIFT is ignored
    start = 1'b1; bin = 8'd37;
    tick();
    start = 1'b0;
    tick();
    tick();
    start = 1'b1; bin = 8'd200;
    tick();
    start = 1'b0; bin = 8'd0;
    wait_done(cyc);
    check("ign_lat", cyc, 5);
    check("ign_bcd", bcd, 12'h037);

    // back-to-back start from the DONE cycle
    start = 1'b1; bin = 8'd10;
    tick();
    start = 1'b0;
    check("b2b_busy", busy, 1);
    wait_done(cyc);
    check("b2b_lat", cyc, 8);
    check("b2b_bcd", bcd, 12'h010);
    tick();

    // reset mid-conversion
    start = 1'b1; bin = 8'd77;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_bcd", bcd, 12'h000);
    check("abort_done", done, 0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) pulses++;
    end
    check("abort_quiet", pulses, 0);

    // exhaustive back-to-back sweep
    start = 1'b1; bin = 8'd0;
    tick();
    start = 1'b0;
    for (int x = 0; x < 256; x++) begin
      wait_done(cyc);
      check($sformatf("sweep_lat_%0d", x), cyc, 8);
      check($sformatf("sweep_%0d", x), bcd, bcd_ref(x));
      if (x < 255) begin
        start = 1'b1;
        bin   = 8'(x + 1);
      end
      tick();
      start = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
